// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - one-word buffered 16-bit serial frame transmitter for the SPI-style DAC
module dac_serial_tx #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        SCLK,
  input  logic        reset,
  input  logic        tx_en,
  input  logic [11:0] data_in,
  input  logic [1:0]  pd_mode,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done_tick,
  output logic        SYNC,
  output logic        DIN
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        hold_valid, hold_valid_n;
  logic [15:0] hold_word;
  logic [15:0] shreg, shreg_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [3:0]  gap_cnt, gap_cnt_n;
  logic        sync_n, din_n, done_n, busy_n;
  logic        load;
  logic        accept;

  // A word is taken only while the single holding slot is empty; otherwise it is dropped.
  assign accept   = tx_en & ~hold_valid;
  assign tx_ready = ~hold_valid;

  // Next-state and next-output decode; frame load is shared by IDLE and the end of the gap.
  always_comb begin
    state_n      = state;
    hold_valid_n = hold_valid | accept;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    sync_n       = SYNC;
    din_n        = DIN;
    done_n       = 1'b0;
    load         = 1'b0;

    case (state)
      IDLE: begin
        if (hold_valid) load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt == 4'd0) begin
          state_n   = DONE;
          sync_n    = 1'b1;
          din_n     = 1'b0;
          done_n    = 1'b1;
          gap_cnt_n = 4'(GAP_CYCLES - 1);
        end else begin
          din_n     = shreg[15];
          shreg_n   = {shreg[14:0], 1'b0};
          bit_cnt_n = bit_cnt - 4'd1;
        end
      end
      DONE, GAP: begin
        if (gap_cnt == 4'd0) begin
          if (hold_valid) load = 1'b1;
          else            state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
          state_n   = GAP;
        end
      end
      default: begin
        state_n = IDLE;
        sync_n  = 1'b1;
        din_n   = 1'b0;
      end
    endcase

    if (load) begin
      state_n      = SHIFT;
      hold_valid_n = 1'b0;
      shreg_n      = {hold_word[14:0], 1'b0};
      din_n        = hold_word[15];
      sync_n       = 1'b0;
      bit_cnt_n    = 4'd15;
    end

    busy_n = (state_n != IDLE);
  end

  // State, counters, pins and holding buffer; reset aborts any frame with SYNC high at once.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hold_valid   <= 1'b0;
      hold_word    <= 16'h0000;
      shreg        <= 16'h0000;
      bit_cnt      <= 4'd0;
      gap_cnt      <= 4'd0;
      SYNC         <= 1'b1;
      DIN          <= 1'b0;
      tx_done_tick <= 1'b0;
      tx_busy      <= 1'b0;
    end else begin
      state        <= state_n;
      hold_valid   <= hold_valid_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_cnt_n;
      gap_cnt      <= gap_cnt_n;
      SYNC         <= sync_n;
      DIN          <= din_n;
      tx_done_tick <= done_n;
      tx_busy      <= busy_n;
      if (accept) hold_word <= {2'b00, pd_mode, data_in};
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - randomized timeline-model bench for dac_serial_tx at gap 2 and gap 5
module tb_dac_serial_tx;

  logic        SCLK = 1'b0;
  logic        reset = 1'b1;
  logic        tx_en = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic [1:0]  pd_mode = 2'b00;

  logic ready2, busy2, tick2, sync2, din2;
  logic ready5, busy5, tick5, sync5, din5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 SCLK = ~SCLK;

  dac_serial_tx #(.GAP_CYCLES(2)) dut2 (
    .SCLK(SCLK), .reset(reset), .tx_en(tx_en), .data_in(data_in), .pd_mode(pd_mode),
    .tx_ready(ready2), .tx_busy(busy2), .tx_done_tick(tick2), .SYNC(sync2), .DIN(din2)
  );

  dac_serial_tx #(.GAP_CYCLES(5)) dut5 (
    .SCLK(SCLK), .reset(reset), .tx_en(tx_en), .data_in(data_in), .pd_mode(pd_mode),
    .tx_ready(ready5), .tx_busy(busy5), .tx_done_tick(tick5), .SYNC(sync5), .DIN(din5)
  );

  // Reference: a frame is a timeline; k counts edges since T0, bits at k=0..15, tick at k=16,
  // busy until k reaches 16+gap, after which a buffered word may start on that same edge.
  typedef struct {
    bit          hold;
    logic [15:0] hold_w;
    logic [15:0] cur;
    bit          active;
    int          k;
  } model_t;

  model_t m2, m5;

  function automatic model_t model_reset();
    model_t r;
    r.hold = 0; r.hold_w = 16'h0; r.cur = 16'h0; r.active = 0; r.k = 0;
    return r;
  endfunction

  function automatic model_t step(model_t m, logic en, logic [13:0] w, int gap);
    model_t r = m;
    bit hold_pre = m.hold;
    if (r.active) begin
      r.k++;
      if (r.k >= 16 + gap) r.active = 0;
    end
    if (!r.active && hold_pre) begin
      r.active = 1; r.k = 0; r.cur = m.hold_w; r.hold = 0;
    end
    if (en && !hold_pre) begin
      r.hold = 1; r.hold_w = {2'b00, w};
    end
    return r;
  endfunction

  // Expected {SYNC, DIN, tx_ready, tx_busy, tx_done_tick}
  function automatic logic [4:0] expv(model_t m);
    logic s, d;
    s = 1'b1; d = 1'b0;
    if (m.active && m.k < 16) begin
      s = 1'b0; d = m.cur[15 - m.k];
    end
    return {s, d, !m.hold, m.active, (m.active && m.k == 16)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One SCLK cycle: drive at negedge, advance models at posedge, compare at next negedge.
  task automatic cyc(input logic en, input logic [11:0] d, input logic [1:0] p);
    tx_en = en; data_in = d; pd_mode = p;
    @(posedge SCLK);
    if (reset) begin
      m2 = model_reset();
      m5 = model_reset();
    end else begin
      m2 = step(m2, en, {p, d}, 2);
      m5 = step(m5, en, {p, d}, 5);
    end
    @(negedge SCLK);
    check("outs_gap2", {27'b0, sync2, din2, ready2, busy2, tick2}, {27'b0, expv(m2)});
    check("outs_gap5", {27'b0, sync5, din5, ready5, busy5, tick5}, {27'b0, expv(m5)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'($urandom), 2'($urandom));
  endtask

  initial begin
    m2 = model_reset();
    m5 = model_reset();
    @(negedge SCLK);
    cyc(1'b0, 12'h000, 2'b00);
    cyc(1'b0, 12'h000, 2'b00);
    reset = 1'b0;
    idle(5);

    // Single frame 0x0A5C, inputs scrambled afterwards, next word lands on the gap-end edge
    cyc(1'b1, 12'hA5C, 2'b00);
    idle(18);
    cyc(1'b1, 12'h6B1, 2'b01);
    idle(30);

    // Back-to-back: second word during shift, third dropped while buffer is full
    cyc(1'b1, 12'h123, 2'b01);
    idle(5);
    cyc(1'b1, 12'hFFF, 2'b00);
    idle(3);
    cyc(1'b1, 12'h777, 2'b10);
    idle(50);

    // Reset at T8 with a second word buffered
    cyc(1'b1, 12'h3C3, 2'b11);
    cyc(1'b0, 12'h000, 2'b00);
    cyc(1'b1, 12'h5A5, 2'b10);
    for (int i = 0; i < 20 && !(m2.active && m2.k == 8); i++) idle(1);
    reset = 1'b1;
    #1;
    check("abort_sync2", {31'b0, sync2}, 32'd1);
    check("abort_tick2", {31'b0, tick2}, 32'd0);
    check("abort_ready2", {31'b0, ready2}, 32'd1);
    check("abort_sync5", {31'b0, sync5}, 32'd1);
    @(negedge SCLK);
    cyc(1'b0, 12'h000, 2'b00);
    reset = 1'b0;
    idle(30);

    // Randomized traffic, including refills during shift/done/gap and dropped words
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 4) == 0, 12'($urandom), 2'($urandom));
    idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_serial_tx.md
# dac_serial_tx

Serial transmitter for the 12-bit SPI-style DAC on the analog output path, the transmit counterpart of the ADC receive block. It accepts a 12-bit sample plus a 2-bit power-down mode through a ready/enable handshake, buffers one word, and shifts a 16-bit frame MSB-first on DIN while holding the frame-select line SYNC low. A guaranteed SYNC-high gap separates frames. It sits between the sample-processing logic and the DAC pins and shares SCLK with the ADC receiver.

## Interface
- GAP_CYCLES, 2, minimum SCLK cycles SYNC stays high between frames; legal range 1..15.
- SCLK  input  1  serial clock; all logic on posedge. The DAC samples DIN on negedge.
- reset  input  1  asynchronous, active-high.
- tx_en  input  1  request to send; sampled on posedge.
- data_in  input  12  DAC sample; captured when the word is accepted.
- pd_mode  input  2  DAC power-down bits; captured with data_in.
- tx_ready  output  1  registered; 1 = holding buffer empty, word can be accepted.
- tx_busy  output  1  registered; 1 while the state is not IDLE.
- tx_done_tick  output  1  registered one-cycle pulse at the end of each frame.
- SYNC  output  1  registered, active-low frame select.
- DIN  output  1  registered serial data, MSB first.

## Operation
- Frame word: {2'b00, pd_mode, data_in[11:0]}, 16 bits, bit 15 sent first.
- Holding buffer:
  - One entry.
  - Accept occurs on a posedge with tx_en=1 and tx_ready=1; the edge stores the word and sets hold_valid.
  - tx_ready = ~hold_valid.
  - tx_en with tx_ready=0 is ignored with no error or flag; that word is lost.
- States and transitions:
  - IDLE: if hold_valid, go to SHIFT. On that edge, load the shift register from the buffer, clear hold_valid, drive SYNC 0 and DIN bit15, and set the bit counter to 15.
  - SHIFT: each edge drives the next bit and decrements the counter. After the edge that drives bit0 (counter=0), the next edge goes to DONE.
  - DONE (one cycle): SYNC goes to 1, DIN goes to 0, tx_done_tick=1, and the gap counter is loaded with GAP_CYCLES-1. Then go to GAP.
  - GAP: count down to 0. Then go to IDLE, or go directly to frame load if hold_valid.
  - Frame load from the end of GAP is identical to the load from IDLE.
- Data capture:
  - The buffer may be refilled at any time, including during SHIFT, DONE or GAP.
  - pd_mode and data_in are captured only at accept. Changes while the word is buffered or shifting have no effect.
- Reset:
  - SYNC=1, DIN=0, tx_ready=1, tx_busy=0, tx_done_tick=0.
  - hold_valid=0, state IDLE, counters 0.
  - Reset mid-frame aborts the frame immediately: SYNC rises asynchronously, there is no tx_done_tick, and the buffered word is discarded.
- Illegal state encodings return to IDLE with SYNC=1.

## Timing
- Accept at edge E with the block in IDLE: hold_valid is 1 after E. Edge E+1 = T0: SYNC falls, DIN = bit15, tx_ready returns to 1.
- Edges T1..T15 drive bits 14..0. SYNC is low for exactly 16 SCLK cycles.
- Edge T16: SYNC=1, DIN=0, tx_done_tick=1 for the cycle T16..T17.
- tx_busy is 1 from T0 through the last GAP cycle.
- Back-to-back frames: if a second word is buffered before the gap ends, its T0 = T16 + GAP_CYCLES. With the default, SYNC is high for exactly 2 cycles.
- Word accepted in the same edge the GAP ends: hold_valid is not yet visible, so the block goes to IDLE and the frame starts one edge later.
- Throughput at default gap: one frame per 18 SCLK cycles.

## Test plan
- Reset, then idle 5 cycles -> SYNC=1, DIN=0, tx_ready=1, tx_busy=0, tx_done_tick=0 throughout.
- Single frame: data_in=12'hA5C, pd_mode=00, tx_en pulsed 1 cycle -> next edge SYNC low for 16 cycles; DIN = 0000_1010_0101_1100; then one tx_done_tick; tx_busy low 2 cycles after DONE.
- Back-to-back: accept 12'h123 (pd=01), accept 12'hFFF during its SHIFT -> second frame 0x0FFF starts with SYNC high exactly 2 cycles. tx_en asserted during the first frame while the buffer is full -> third word dropped, tx_ready=0 until the second frame's T0.
- Input change after accept: alter data_in and pd_mode during the buffered and shifting periods -> transmitted word unchanged.
- Reset asserted at T8 of a frame with a word buffered -> SYNC=1 immediately; no tx_done_tick; no frame after release until a new accept.
- GAP_CYCLES=5 build: two buffered words -> SYNC high exactly 5 cycles between frames.
